// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the round-robin master and a single APB slave.
interface apb_master_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  selx;
   logic                  enable;
   logic                  write;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;
   logic                  slverr;

   modport master (
      output selx, enable, write, addr, wdata,
      input  rdata, ready, slverr
   );

   modport slave (
      input  selx, enable, write, addr, wdata,
      output rdata, ready, slverr
   );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: arbitrates N_REQ requesters onto one APB bus,
// sequences SETUP/ACCESS, handles wait states and aborts hung transfers.
module apb_master_arbiter #(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_write,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [N_REQ-1:0]            req_accept,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]       rsp_rdata,
   output logic                        rsp_slverr,
   output logic                        rsp_timeout,
   apb_master_arbiter_if.master        apb
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_selx, w_selx_nxt;
   logic                  r_enable, w_enable_nxt;
   logic                  r_write, w_write_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
   logic [N_REQ-1:0]      r_accept, w_accept_nxt;
   logic [N_REQ-1:0]      r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic                  r_rsp_slverr, w_rsp_slverr_nxt;
   logic                  r_rsp_timeout, w_rsp_timeout_nxt;
   logic [PW-1:0]         r_ptr, w_ptr_nxt;
   logic [PW-1:0]         r_gnt, w_gnt_nxt;
   logic [WW-1:0]         r_wait, w_wait_nxt;

   logic                  w_arb_found;
   logic [PW-1:0]         w_arb_idx;
   int                    w_cand;
   logic                  w_launch;
   logic                  w_timeout_hit;

   // First pending requester at or after the pointer, wrapping mod N_REQ.
   always_comb begin
      w_arb_found = 1'b0;
      w_arb_idx   = '0;
      w_cand      = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         w_cand = int'(r_ptr) + int'(i);
         if (w_cand >= N_REQ) w_cand = w_cand - N_REQ;
         if (!w_arb_found && req_valid[w_cand[PW-1:0]]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = w_cand[PW-1:0];
         end
      end
   end

   assign w_timeout_hit = (TIMEOUT != 0) && (r_wait == WW'(TIMEOUT - 1));

   always_comb begin
      w_state_nxt       = r_state;
      w_selx_nxt        = r_selx;
      w_enable_nxt      = r_enable;
      w_write_nxt       = r_write;
      w_addr_nxt        = r_addr;
      w_wdata_nxt       = r_wdata;
      w_accept_nxt      = '0;
      w_rsp_valid_nxt   = '0;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_slverr_nxt  = r_rsp_slverr;
      w_rsp_timeout_nxt = r_rsp_timeout;
      w_ptr_nxt         = r_ptr;
      w_gnt_nxt         = r_gnt;
      w_wait_nxt        = r_wait;
      w_launch          = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_selx_nxt   = 1'b0;
            w_enable_nxt = 1'b0;
            w_launch     = w_arb_found;
         end
         S_SETUP: begin
            w_enable_nxt = 1'b1;
            w_state_nxt  = S_ACCESS;
         end
         S_ACCESS: begin
            if (apb.ready) begin
               w_rsp_valid_nxt[r_gnt] = 1'b1;
               w_rsp_rdata_nxt        = r_write ? '0 : apb.rdata;
               w_rsp_slverr_nxt       = apb.slverr;
               w_rsp_timeout_nxt      = 1'b0;
               w_wait_nxt             = '0;
               w_enable_nxt           = 1'b0;
               w_launch               = w_arb_found;
               if (!w_arb_found) begin
                  w_selx_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
               end
            end else if (w_timeout_hit) begin
               w_rsp_valid_nxt[r_gnt] = 1'b1;
               w_rsp_rdata_nxt        = '0;
               w_rsp_slverr_nxt       = 1'b1;
               w_rsp_timeout_nxt      = 1'b1;
               w_wait_nxt             = '0;
               w_selx_nxt             = 1'b0;
               w_enable_nxt           = 1'b0;
               w_state_nxt            = S_IDLE;
            end else begin
               w_wait_nxt = r_wait + WW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Shared by the IDLE grant and the back-to-back grant at ACCESS completion.
      if (w_launch) begin
         w_selx_nxt              = 1'b1;
         w_enable_nxt            = 1'b0;
         w_write_nxt             = req_write[w_arb_idx];
         w_addr_nxt              = req_addr[w_arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
         w_wdata_nxt             = req_wdata[w_arb_idx*DATA_WIDTH +: DATA_WIDTH];
         w_accept_nxt[w_arb_idx] = 1'b1;
         w_gnt_nxt               = w_arb_idx;
         w_ptr_nxt               = (w_arb_idx == PW'(N_REQ - 1)) ? '0 : w_arb_idx + PW'(1);
         w_state_nxt             = S_SETUP;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_selx        <= 1'b0;
         r_enable      <= 1'b0;
         r_write       <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_accept      <= '0;
         r_rsp_valid   <= '0;
         r_rsp_rdata   <= '0;
         r_rsp_slverr  <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_ptr         <= '0;
         r_gnt         <= '0;
         r_wait        <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_selx        <= w_selx_nxt;
         r_enable      <= w_enable_nxt;
         r_write       <= w_write_nxt;
         r_addr        <= w_addr_nxt;
         r_wdata       <= w_wdata_nxt;
         r_accept      <= w_accept_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_slverr  <= w_rsp_slverr_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
         r_ptr         <= w_ptr_nxt;
         r_gnt         <= w_gnt_nxt;
         r_wait        <= w_wait_nxt;
      end
   end

   assign apb.selx    = r_selx;
   assign apb.enable  = r_enable;
   assign apb.write   = r_write;
   assign apb.addr    = r_addr;
   assign apb.wdata   = r_wdata;
   assign req_accept  = r_accept;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_slverr  = r_rsp_slverr;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Round-robin APB master that shares one APB bus between N_REQ local requesters.
- Arbitrates among pending requests and sequences the IDLE -> SETUP -> ACCESS phases.
- Holds address, write and wdata stable through each transfer, handles wait states and aborts hung transfers with a timeout.
- Returns rdata and slverr to the granted requester; sits between the bus-side requester logic and the APB slave.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 10, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles with ready low before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  request pending, one bit per requester.
- req_write  in  N_REQ  1 = write, 0 = read, per requester.
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  N_REQ*DATA_WIDTH  packed write data.
- req_accept  out  N_REQ  one-cycle pulse: request i latched.
- rsp_valid  out  N_REQ  one-cycle pulse: transfer of requester i finished.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_slverr  out  1  error flag, valid with rsp_valid.
- rsp_timeout  out  1  with rsp_valid: the transfer was aborted by timeout.
- selx  out  1  APB select.
- enable  out  1  APB enable.
- write  out  1  APB direction.
- addr  out  ADDR_WIDTH  APB address.
- wdata  out  DATA_WIDTH  APB write data.
- rdata  in  DATA_WIDTH  APB read data.
- ready  in  1  APB ready.
- slverr  in  1  APB slave error.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. Reset also clears state to IDLE, the round-robin pointer (next candidate = requester 0) and the wait counter.
- Reset asserted mid-transfer:
  - Abandons the transfer immediately; selx and enable drop asynchronously.
  - No rsp_valid is issued for the abandoned transfer.
- Requester contract:
  - Hold req_valid and its fields stable until req_accept[i].
  - Deassert req_valid or present a new request the cycle after req_accept[i].
- State IDLE:
  - selx = 0, enable = 0; addr, write and wdata hold their last values (not zeroed).
  - If any req_valid is high at an edge: grant the first set bit scanning from pointer, pointer+1, … (mod N_REQ).
  - On that grant: latch addr/write/wdata (wdata latched for reads too), set selx = 1, pulse req_accept[g] for 1 cycle, set pointer = g+1 mod N_REQ, go to SETUP.
- State SETUP (exactly 1 cycle): selx = 1, enable = 0; next edge goes to ACCESS with enable = 1.
- State ACCESS:
  - selx = 1, enable = 1; addr, write and wdata stay unchanged.
  - Each edge with ready = 0 increments the wait counter.
  - Edge with ready = 1:
    - Capture rdata (writes return 0 on rsp_rdata) and slverr.
    - Pulse rsp_valid[g] the following cycle; rsp_timeout = 0.
    - Clear the counter and drop enable.
    - If any req_valid is high at this same edge: arbitrate as in IDLE, latch the new request, keep selx = 1, go to SETUP (back-to-back transfer, no IDLE cycle). Otherwise drop selx and go to IDLE.
  - Timeout (TIMEOUT != 0 and counter reaches TIMEOUT with ready still 0):
    - Drop selx and enable, go to IDLE.
    - Pulse rsp_valid[g] with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
- Latency:
  - Zero wait states: the edge that sees req_valid starts SETUP in the next cycle, ACCESS follows, and rsp_valid pulses 3 cycles after that edge.
  - Each wait state adds 1 cycle.
- Simultaneous requests:
  - Resolved strictly by the rotating pointer.
  - A requester just served has the lowest priority for the next grant.
- Bus rules the block guarantees:
  - enable is never high without selx.
  - enable is high for exactly one SETUP-to-ACCESS transition per transfer.
  - rsp_valid is one-hot or zero.
  - At most one transfer is outstanding.

Test Plan:
- Single write, zero wait: req0 valid, addr=0x155, wdata=0xDEADBEEF -> selx high for 2 cycles, enable in the 2nd; addr/wdata stable for both; rsp_valid[0] pulses once with slverr = 0.
- Read with 3 wait states: req1 read addr=0x3FF, ready low 3 ACCESS cycles then high with rdata=0x12345678 -> enable high for 4 cycles; rsp_rdata=0x12345678 with rsp_valid[1] one cycle after ready.
- Contention: req0 and req1 held valid continuously from reset -> grants alternate 0, 1, 0, 1; back-to-back transfers with selx held high; enable drops each SETUP.
- Slave error: slverr = 1 with ready on a write -> rsp_slverr = 1, rsp_timeout = 0; next request still served normally.
- Timeout: TIMEOUT=16, ready held 0 -> after 16 ACCESS cycles selx/enable drop; rsp_valid with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
- Reset mid-ACCESS: resetn low while enable = 1 -> all outputs 0 immediately; no rsp_valid; after release the first grant goes to requester 0.
